ahb_slave_mem: RTL

AHB word-memory slave that consumes the address/control and write-data phases driven by ahb_master2 through the decoder/mux. It implements the pipelined address/data phase split, a programmable number of wait states, byte/halfword/word lanes, and the two-cycle ERROR and RETRY responses that the master's retry/error recovery paths exercise. Storage is a local RAM array.

---
 rtl/ahb_slave_mem_pkg.sv | 80 ++++++++
 rtl/ahb_slave_ram.sv | 40 ++++
 rtl/ahb_slave_mem.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_slave_mem_pkg.sv
// Shared AHB types and helpers for the word-memory slave.
//   type_htrans    : HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   type_hburst    : HBURST encodings (informational only)
//   type_hsize     : HSIZE encodings; anything above WORD is illegal here
//   type_hresp     : HRESP encodings
//   type_slv_state : data-phase FSM states of ahb_slave_mem
//   size_align_err : illegal size or misaligned address for that size
//   lane_mask      : little-endian byte-lane enables for a transfer
//   byte_mask32    : expands 4 lane enables into a 32-bit bit mask
package ahb_slave_mem_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } type_htrans;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } type_hburst;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } type_hsize;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } type_hresp;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_WAIT  = 3'b001,
        ST_LAST  = 3'b010,
        ST_RESP1 = 3'b011,
        ST_RESP2 = 3'b100
    } type_slv_state;

    function automatic logic size_align_err(input logic [2:0] size, input logic [1:0] addr_lo);
        logic err;
        case (size)
            HSIZE_BYTE: err = 1'b0;
            HSIZE_HALF: err = addr_lo[0];
            HSIZE_WORD: err = (addr_lo != 2'b00);
            default:    err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << addr_lo;
            HSIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] byte_mask32(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// MEM_DEPTH x 32-bit storage with byte-enable synchronous write and
// combinational read. Contents are deliberately not reset.
//   clk   : clock
//   we    : write strobe for this edge
//   be    : byte-lane enables (bit n -> wdata[8n+7:8n])
//   waddr : word index written
//   wdata : write data
//   raddr : word index read
//   rdata : word at raddr (combinational)
module ahb_slave_ram
    import ahb_slave_mem_pkg::*;
#(
    parameter int MEM_DEPTH = 64,
    parameter int AW        = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [MEM_DEPTH];

    // Byte-lane masked write on the edge that ends a write data phase.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB word-memory slave: pipelined address/data phases, WAIT_STATES wait
// cycles per OKAY transfer, byte/half/word lanes, two-cycle ERROR/RETRY.
//   HCLK, HRESETN : clock, async active-low reset
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST : address phase
//   HWDATA        : write data (data phase)
//   HREADY        : bus-level ready (end of previous data phase)
//   retry_req     : forces RETRY on the transfer sampled this cycle
//   HRDATA, HREADYOUT, HRESP : data-phase response (all registered)
module ahb_slave_mem
    import ahb_slave_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MEM_DEPTH   = 64,
    parameter int          WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        retry_req,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0] WS_INIT = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : {CW{1'b0}};

    type_slv_state state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          hreadyout_r, rdy_s;
    type_hresp     hresp_r, resp_s;
    logic [31:0]   hrdata_r, rdata_s;

    // Transfer captured at accept; pend_r marks an OKAY transfer owning the data phase.
    logic [AW-1:0] idx_r;
    logic          wr_r;
    logic [3:0]    be_r;
    logic          pend_r;

    logic [31:0]   off_s;
    logic          accept_s, err_s, ok_s, ready_state_s;
    logic [AW-1:0] new_idx_s, rd_idx_s;
    logic          we_s;
    logic [31:0]   ram_rdata_s, wmask_s, fwd_s;
    logic          unused_s;

    // Address-phase decode: accept condition and check outcomes.
    always_comb begin
        off_s         = HADDR - BASE_ADDR;
        new_idx_s     = off_s[AW+1:2];
        ready_state_s = (state_r == ST_IDLE) || (state_r == ST_LAST) || (state_r == ST_RESP2);
        accept_s      = HSEL && HREADY && ready_state_s &&
                        ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
        err_s         = (HADDR < BASE_ADDR) || (off_s[31:2] >= 30'(MEM_DEPTH)) ||
                        size_align_err(HSIZE, HADDR[1:0]);
        ok_s          = !err_s && !retry_req;
    end

    // RAM port control; read forwards the write completing on the same edge.
    always_comb begin
        we_s     = pend_r && wr_r && hreadyout_r;
        rd_idx_s = (state_r == ST_WAIT) ? idx_r : new_idx_s;
        wmask_s  = byte_mask32(be_r);
        if (we_s && (idx_r == new_idx_s)) begin
            fwd_s = (ram_rdata_s & ~wmask_s) | (HWDATA & wmask_s);
        end else begin
            fwd_s = ram_rdata_s;
        end
    end

    // Next state, wait counter and next-cycle response.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        rdy_s   = 1'b1;
        resp_s  = HRESP_OKAY;
        case (state_r)
            ST_IDLE, ST_LAST, ST_RESP2: begin
                if (accept_s && err_s) begin
                    state_s = ST_RESP1;
                    rdy_s   = 1'b0;
                    resp_s  = HRESP_ERROR;
                end else if (accept_s && retry_req) begin
                    state_s = ST_RESP1;
                    rdy_s   = 1'b0;
                    resp_s  = HRESP_RETRY;
                end else if (accept_s && (WAIT_STATES > 0)) begin
                    state_s = ST_WAIT;
                    cnt_s   = WS_INIT;
                    rdy_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = ST_LAST;
                end else begin
                    cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    rdy_s = 1'b0;
                end
            end
            ST_RESP1: begin
                state_s = ST_RESP2;
                resp_s  = hresp_r;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Read data for the next cycle: loaded only when that cycle is ready, held otherwise.
    always_comb begin
        rdata_s = hrdata_r;
        if (rdy_s) begin
            if (state_r == ST_WAIT) begin
                rdata_s = wr_r ? 32'h0000_0000 : ram_rdata_s;
            end else if (accept_s && ok_s && !HWRITE) begin
                rdata_s = fwd_s;
            end else begin
                rdata_s = 32'h0000_0000;
            end
        end else begin
            rdata_s = hrdata_r;
        end
    end

    // FSM state and registered bus outputs.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
            hrdata_r    <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            hreadyout_r <= rdy_s;
            hresp_r     <= resp_s;
            hrdata_r    <= rdata_s;
        end
    end

    // Capture the accepted transfer; clear ownership when its data phase ends.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            idx_r  <= {AW{1'b0}};
            wr_r   <= 1'b0;
            be_r   <= 4'b0000;
            pend_r <= 1'b0;
        end else if (accept_s) begin
            idx_r  <= new_idx_s;
            wr_r   <= HWRITE;
            be_r   <= lane_mask(HSIZE, HADDR[1:0]);
            pend_r <= ok_s;
        end else if (hreadyout_r) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= pend_r;
        end
    end

    ahb_slave_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk   (HCLK),
        .we    (we_s),
        .be    (be_r),
        .waddr (idx_r),
        .wdata (HWDATA),
        .raddr (rd_idx_s),
        .rdata (ram_rdata_s)
    );

    assign HRDATA    = hrdata_r;
    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;

    // HBURST is informational; the low offset bits are covered by HADDR checks.
    assign unused_s  = ^{HBURST, off_s[1:0]};

endmodule
